poly_dispatch_arb: RTL and testbench

POLY_DISPATCH_ARB -- requirements
Module: poly_dispatch_arb

---
 rtl/poly_dispatch_arb.sv | 145 ++++++++++++++
 tb/tb_poly_dispatch_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_dispatch_arb.sv
// Polygon dispatch arbiter: two requesters (A, B) each feed a 2-entry FIFO,
// and a round-robin arbiter drains both into one registered output stage
// toward the rasterizer. Delivered polygons are counted per requester.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   polyX_valid/ready        requester X handshake (X = A, B)
//   polyX_poly/color/isQuad  requester X polygon payload (one beat)
//   validPoly_R10H           dispatched polygon valid
//   poly_R10S, color_R10U,
//   isQuad_R10H, src_R10H    dispatched payload and source (0=A, 1=B)
//   halt_RnnnnL              downstream accept (1 = accepts, 0 = stall)
//   dispA_cnt, dispB_cnt     wrapping per-requester delivery counters
//   idle                     both FIFOs empty and output stage empty
module poly_dispatch_arb #(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          polyA_valid,
    output logic                          polyA_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  polyA_poly,
    input  logic [COLORS*SIGFIG-1:0]      polyA_color,
    input  logic                          polyA_isQuad,

    input  logic                          polyB_valid,
    output logic                          polyB_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  polyB_poly,
    input  logic [COLORS*SIGFIG-1:0]      polyB_color,
    input  logic                          polyB_isQuad,

    output logic                          validPoly_R10H,
    output logic [VERTS*AXIS*SIGFIG-1:0]  poly_R10S,
    output logic [COLORS*SIGFIG-1:0]      color_R10U,
    output logic                          isQuad_R10H,
    output logic                          src_R10H,
    input  logic                          halt_RnnnnL,

    output logic [15:0]                   dispA_cnt,
    output logic [15:0]                   dispB_cnt,
    output logic                          idle
);

    localparam int unsigned PW = VERTS * AXIS * SIGFIG;
    localparam int unsigned CW = COLORS * SIGFIG;
    // FIFO entry layout: {isQuad, color, poly}
    localparam int unsigned EW = PW + CW + 1;

    // The fixed-point position is opaque to this block; only sanity-check it.
    if (RADIX > SIGFIG) begin : g_radix_bad
        $error("poly_dispatch_arb: RADIX exceeds SIGFIG");
    end

    logic [EW-1:0] mem_a [2];
    logic [EW-1:0] mem_b [2];
    logic          wr_a, rd_a, wr_b, rd_b;
    logic [1:0]    cnt_a, cnt_b;
    logic          last_b;          // last grant went to B

    logic          push_a, push_b;
    logic          ne_a, ne_b;
    logic          load, deliver;
    logic          grant_a, grant_b;
    logic [EW-1:0] head_a, head_b;

    // Ready depends only on current occupancy, never on a same-cycle pop.
    assign polyA_ready = (cnt_a != 2'd2);
    assign polyB_ready = (cnt_b != 2'd2);
    assign push_a      = polyA_valid & polyA_ready;
    assign push_b      = polyB_valid & polyB_ready;

    assign ne_a    = (cnt_a != 2'd0);
    assign ne_b    = (cnt_b != 2'd0);
    assign load    = ~validPoly_R10H | halt_RnnnnL;
    assign deliver = validPoly_R10H & halt_RnnnnL;

    // Round-robin: on a tie the port opposite the last grant wins.
    assign grant_a = load & ne_a & (~ne_b | last_b);
    assign grant_b = load & ne_b & (~ne_a | ~last_b);

    assign head_a = mem_a[rd_a];
    assign head_b = mem_b[rd_b];

    assign idle = (cnt_a == 2'd0) & (cnt_b == 2'd0) & ~validPoly_R10H;

    // FIFO storage; occupancy is reset separately so contents need no reset.
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wr_a] <= {polyA_isQuad, polyA_color, polyA_poly};
        if (push_b) mem_b[wr_b] <= {polyB_isQuad, polyB_color, polyB_poly};
    end

    // FIFO pointers, arbiter state, output stage and delivery counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a           <= 1'b0;
            rd_a           <= 1'b0;
            cnt_a          <= 2'd0;
            wr_b           <= 1'b0;
            rd_b           <= 1'b0;
            cnt_b          <= 2'd0;
            last_b         <= 1'b1;
            validPoly_R10H <= 1'b0;
            poly_R10S      <= '0;
            color_R10U     <= '0;
            isQuad_R10H    <= 1'b0;
            src_R10H       <= 1'b0;
            dispA_cnt      <= 16'd0;
            dispB_cnt      <= 16'd0;
        end else begin
            if (push_a)  wr_a <= ~wr_a;
            if (grant_a) rd_a <= ~rd_a;
            cnt_a <= cnt_a + 2'(push_a) - 2'(grant_a);

            if (push_b)  wr_b <= ~wr_b;
            if (grant_b) rd_b <= ~rd_b;
            cnt_b <= cnt_b + 2'(push_b) - 2'(grant_b);

            // Count the polygon leaving the output stage at this edge.
            if (deliver) begin
                if (src_R10H) dispB_cnt <= dispB_cnt + 16'd1;
                else          dispA_cnt <= dispA_cnt + 16'd1;
            end

            // Output stage reloads when empty or when its content is taken.
            if (load) begin
                validPoly_R10H <= grant_a | grant_b;
                if (grant_a) begin
                    {isQuad_R10H, color_R10U, poly_R10S} <= head_a;
                    src_R10H <= 1'b0;
                    last_b   <= 1'b0;
                end else if (grant_b) begin
                    {isQuad_R10H, color_R10U, poly_R10S} <= head_b;
                    src_R10H <= 1'b1;
                    last_b   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_dispatch_arb.sv
// Directed self-checking bench for poly_dispatch_arb (default parameters).
module tb_poly_dispatch_arb;

    localparam int unsigned PW = 216;
    localparam int unsigned CW = 72;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_quad;
    logic [PW-1:0] a_poly;
    logic [CW-1:0] a_color;
    logic          b_valid, b_ready, b_quad;
    logic [PW-1:0] b_poly;
    logic [CW-1:0] b_color;
    logic          o_valid, o_quad, o_src, halt;
    logic [PW-1:0] o_poly;
    logic [CW-1:0] o_color;
    logic [15:0]   cnt_a, cnt_b;
    logic          idle;

    int n_tests = 0;
    int n_fail  = 0;

    poly_dispatch_arb dut (
        .clk            (clk),
        .rst            (rst),
        .polyA_valid    (a_valid),
        .polyA_ready    (a_ready),
        .polyA_poly     (a_poly),
        .polyA_color    (a_color),
        .polyA_isQuad   (a_quad),
        .polyB_valid    (b_valid),
        .polyB_ready    (b_ready),
        .polyB_poly     (b_poly),
        .polyB_color    (b_color),
        .polyB_isQuad   (b_quad),
        .validPoly_R10H (o_valid),
        .poly_R10S      (o_poly),
        .color_R10U     (o_color),
        .isQuad_R10H    (o_quad),
        .src_R10H       (o_src),
        .halt_RnnnnL    (halt),
        .dispA_cnt      (cnt_a),
        .dispB_cnt      (cnt_b),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; halt = 1'b1;
        a_quad = 1'b0; b_quad = 1'b0; a_color = '0; b_color = '0;
        a_poly = '0; b_poly = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b1;
        a_valid = 1'b1; a_poly = PW'(5); a_color = CW'(9); a_quad = 1'b1;
        b_valid = 1'b1; b_poly = PW'(6); b_color = CW'(8); b_quad = 1'b1;
        tick();
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
        n_tests++; if (o_src !== 1'b0) begin n_fail++; $display("FAIL rst_src: got %0b want 0", o_src); end
        n_tests++; if (o_quad !== 1'b0) begin n_fail++; $display("FAIL rst_quad: got %0b want 0", o_quad); end
        n_tests++; if (o_poly !== '0) begin n_fail++; $display("FAIL rst_poly: got %0h want 0", o_poly); end
        n_tests++; if (o_color !== '0) begin n_fail++; $display("FAIL rst_color: got %0h want 0", o_color); end
        n_tests++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0h/%0h want 0/0", cnt_a, cnt_b); end
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b/%0b want 1/1", a_ready, b_ready); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0b want 1", idle); end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        tick();
        tick();
        n_tests++; if (o_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rst_discard: valid %0b idle %0b want 0 1", o_valid, idle); end
    endtask

    task automatic test_single();
        do_reset();
        a_poly = PW'(1); a_color = CW'(24'h123456); a_quad = 1'b0; a_valid = 1'b1;
        tick();                                  // edge 0: push
        a_valid = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_e0_valid: got %0b want 0", o_valid); end
        tick();                                  // edge 1: load
        n_tests++; if (o_valid !== 1'b1 || o_src !== 1'b0) begin n_fail++; $display("FAIL single_e1: valid %0b src %0b want 1 0", o_valid, o_src); end
        n_tests++; if (o_poly !== PW'(1) || o_color !== CW'(24'h123456) || o_quad !== 1'b0) begin n_fail++; $display("FAIL single_data: poly %0h color %0h quad %0b", o_poly, o_color, o_quad); end
        n_tests++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL single_e1_cnt: got %0d want 0", cnt_a); end
        tick();                                  // edge 2: delivered
        n_tests++; if (cnt_a !== 16'd1 || cnt_b !== 16'd0) begin n_fail++; $display("FAIL single_e2_cnt: got %0d/%0d want 1/0", cnt_a, cnt_b); end
        n_tests++; if (idle !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL single_e2_idle: idle %0b valid %0b want 1 0", idle, o_valid); end
    endtask

    task automatic test_alternate();
        int va, vb, na, nb, diff;
        logic acc_a, acc_b, exp_src;
        do_reset();
        va = 0; vb = 0; na = 0; nb = 0; exp_src = 1'b0;
        for (int i = 0; i < 12; i++) begin
            a_poly = PW'(32'hA00 + va); b_poly = PW'(32'hB00 + vb);
            a_valid = 1'b1; b_valid = 1'b1;
            acc_a = a_ready; acc_b = b_ready;
            tick();
            if (acc_a) va++;
            if (acc_b) vb++;
            if (i >= 1) begin
                n_tests++; if (o_valid !== 1'b1 || o_src !== exp_src) begin n_fail++; $display("FAIL alt_src[%0d]: valid %0b src %0b want 1 %0b", i, o_valid, o_src, exp_src); end
                if (exp_src == 1'b0) begin
                    n_tests++; if (o_poly !== PW'(32'hA00 + na)) begin n_fail++; $display("FAIL alt_a_data[%0d]: got %0h want %0h", i, o_poly, 32'hA00 + na); end
                    na++;
                end else begin
                    n_tests++; if (o_poly !== PW'(32'hB00 + nb)) begin n_fail++; $display("FAIL alt_b_data[%0d]: got %0h want %0h", i, o_poly, 32'hB00 + nb); end
                    nb++;
                end
                exp_src = ~exp_src;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        diff = int'(cnt_a) - int'(cnt_b);
        n_tests++; if (cnt_a !== 16'd5 || cnt_b !== 16'd5 || diff > 1 || diff < -1) begin n_fail++; $display("FAIL alt_cnt: got %0d/%0d want 5/5", cnt_a, cnt_b); end
    endtask

    task automatic test_halt_fill();
        int va;
        logic acc;
        do_reset();
        halt = 1'b0; va = 0;
        for (int i = 0; i < 6; i++) begin
            a_poly = PW'(32'hC00 + va); a_valid = 1'b1;
            acc = a_ready;
            tick();
            if (acc) va++;
            if (i >= 1) begin
                n_tests++; if (o_valid !== 1'b1 || o_poly !== PW'(32'hC00)) begin n_fail++; $display("FAIL halt_hold[%0d]: valid %0b poly %0h want 1 c00", i, o_valid, o_poly); end
            end
        end
        n_tests++; if (va !== 3) begin n_fail++; $display("FAIL halt_accepted: got %0d want 3", va); end
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready: got %0b want 0", a_ready); end
        n_tests++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL halt_cnt: got %0d want 0", cnt_a); end
        a_valid = 1'b0; halt = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++; if (cnt_a !== 16'(k)) begin n_fail++; $display("FAIL release_cnt[%0d]: got %0d want %0d", k, cnt_a, k); end
            if (k < 3) begin
                n_tests++; if (o_valid !== 1'b1 || o_poly !== PW'(32'hC00 + k)) begin n_fail++; $display("FAIL release_order[%0d]: valid %0b poly %0h want 1 %0h", k, o_valid, o_poly, 32'hC00 + k); end
            end else begin
                n_tests++; if (o_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL release_end: valid %0b idle %0b want 0 1", o_valid, idle); end
            end
        end
    endtask

    task automatic test_only_b();
        int nb;
        do_reset();
        nb = 0;
        b_quad = 1'b1; b_color = CW'(24'hABCDEF);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                b_poly = PW'(32'hD00 + i); b_valid = 1'b1;
                n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL onlyb_ready[%0d]: got %0b want 1", i, b_ready); end
            end else begin
                b_valid = 1'b0;
            end
            tick();
            if (o_valid === 1'b1) begin
                n_tests++; if (o_src !== 1'b1 || o_poly !== PW'(32'hD00 + nb) || o_quad !== 1'b1 || o_color !== CW'(24'hABCDEF)) begin
                    n_fail++; $display("FAIL onlyb_out[%0d]: src %0b poly %0h quad %0b want 1 %0h 1", nb, o_src, o_poly, o_quad, 32'hD00 + nb);
                end
                nb++;
            end
        end
        n_tests++; if (nb !== 5) begin n_fail++; $display("FAIL onlyb_seen: got %0d want 5", nb); end
        n_tests++; if (cnt_b !== 16'd5 || cnt_a !== 16'd0) begin n_fail++; $display("FAIL onlyb_cnt: got %0d/%0d want 0/5", cnt_a, cnt_b); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        a_poly = PW'(7); a_valid = 1'b1; n = 0;
        while (cnt_a !== 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        a_valid = 1'b0;
        n_tests++; if (cnt_a !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_reach: got %0h want ffff", cnt_a); end
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_inflight: got %0b want 1", o_valid); end
        tick();
        n_tests++; if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt: got %0h/%0h want 0/0", cnt_a, cnt_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        halt = 1'b0;
        a_valid = 1'b1; a_poly = PW'(32'hE1); a_color = CW'(3); a_quad = 1'b1;
        b_valid = 1'b1; b_poly = PW'(32'hF1); b_color = CW'(4); b_quad = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || o_valid !== 1'b1 || idle !== 1'b0) begin
            n_fail++; $display("FAIL mid_full: ready %0b/%0b valid %0b idle %0b want 0/0 1 0", a_ready, b_ready, o_valid, idle);
        end
        rst = 1'b1;
        tick();
        n_tests++; if (o_valid !== 1'b0 || o_src !== 1'b0 || o_quad !== 1'b0 || o_poly !== '0 || o_color !== '0) begin
            n_fail++; $display("FAIL mid_outputs: valid %0b src %0b quad %0b poly %0h color %0h want all 0", o_valid, o_src, o_quad, o_poly, o_color);
        end
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b1 || cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            n_fail++; $display("FAIL mid_state: ready %0b/%0b cnt %0d/%0d want 1/1 0/0", a_ready, b_ready, cnt_a, cnt_b);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; halt = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (o_valid !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 16'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL mid_after: valid %0b cnt %0d/%0d idle %0b want 0 0/0 1", o_valid, cnt_a, cnt_b, idle);
        end
    endtask

    initial begin
        rst = 1'b1; halt = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_quad = 1'b0; b_quad = 1'b0;
        a_poly = '0; b_poly = '0; a_color = '0; b_color = '0;
        test_reset();
        test_single();
        test_alternate();
        test_halt_fill();
        test_only_b();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
